// File: rtl/cpu_output_checker.sv
// Streaming checker for CPU trace records, one ASCII character per clock.
// Recognises register/memory write records and reports semantic errors on completion.
module cpu_output_checker (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [15:0] freq,
  output logic [1:0]  format_type,
  output logic [3:0]  error_code
);

  typedef enum logic [3:0] {
    IDLE, TIME, PC, COLON, SEL, GRF, ADDR, LT, EQ, DATA, HASH, DONE_REG, DONE_MEM
  } state_t;

  state_t      state, n_state;
  logic [2:0]  dec_cnt, n_dec;
  logic [3:0]  hex_cnt, n_hex;
  logic [13:0] time_acc, n_time, grf_acc, n_grf;
  logic [31:0] pc_acc, n_pc, addr_acc, n_addr;
  logic        is_mem, n_mem;

  logic       is_dig, is_hex, is_sp;
  logic [3:0] nib;

  assign is_dig = (char >= 8'h30) && (char <= 8'h39);
  assign is_hex = is_dig || ((char >= 8'h61) && (char <= 8'h66));
  assign is_sp  = (char == 8'h20);
  assign nib    = is_dig ? char[3:0] : char[3:0] + 4'd9;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dec_cnt  <= '0;
      hex_cnt  <= '0;
      time_acc <= '0;
      grf_acc  <= '0;
      pc_acc   <= '0;
      addr_acc <= '0;
      is_mem   <= 1'b0;
    end else begin
      state    <= n_state;
      dec_cnt  <= n_dec;
      hex_cnt  <= n_hex;
      time_acc <= n_time;
      grf_acc  <= n_grf;
      pc_acc   <= n_pc;
      addr_acc <= n_addr;
      is_mem   <= n_mem;
    end
  end

  always_comb begin
    n_state = IDLE;
    n_dec   = dec_cnt;
    n_hex   = hex_cnt;
    n_time  = time_acc;
    n_grf   = grf_acc;
    n_pc    = pc_acc;
    n_addr  = addr_acc;
    n_mem   = is_mem;
    // '^' is never legal inside a record, so it always opens a fresh frame
    if (char == 8'h5e) begin
      n_state = TIME;
      n_dec   = '0;
      n_hex   = '0;
      n_time  = '0;
      n_grf   = '0;
      n_pc    = '0;
      n_addr  = '0;
      n_mem   = 1'b0;
    end else begin
      case (state)
        TIME:
          if (is_dig && dec_cnt != 3'd4) begin
            n_state = TIME;
            n_time  = time_acc * 14'd10 + {10'd0, char[3:0]};
            n_dec   = dec_cnt + 3'd1;
          end else if (char == 8'h40 && dec_cnt != 3'd0) begin
            n_state = PC;
            n_hex   = '0;
          end
        PC:
          if (is_hex && hex_cnt != 4'd8) begin
            n_state = PC;
            n_pc    = {pc_acc[27:0], nib};
            n_hex   = hex_cnt + 4'd1;
          end else if (char == 8'h3a && hex_cnt == 4'd8) begin
            n_state = COLON;
          end
        COLON, SEL:
          if (is_sp) n_state = SEL;
          else if (char == 8'h24) begin
            n_state = GRF;
            n_dec   = '0;
          end else if (char == 8'h2a) begin
            n_state = ADDR;
            n_hex   = '0;
            n_mem   = 1'b1;
          end
        GRF:
          if (is_dig && dec_cnt != 3'd4) begin
            n_state = GRF;
            n_grf   = grf_acc * 14'd10 + {10'd0, char[3:0]};
            n_dec   = dec_cnt + 3'd1;
          end else if (dec_cnt != 3'd0 && is_sp) n_state = LT;
          else if (dec_cnt != 3'd0 && char == 8'h3c) n_state = EQ;
        ADDR:
          if (is_hex && hex_cnt != 4'd8) begin
            n_state = ADDR;
            n_addr  = {addr_acc[27:0], nib};
            n_hex   = hex_cnt + 4'd1;
          end else if (hex_cnt == 4'd8 && is_sp) n_state = LT;
          else if (hex_cnt == 4'd8 && char == 8'h3c) n_state = EQ;
        LT:
          if (is_sp) n_state = LT;
          else if (char == 8'h3c) n_state = EQ;
        EQ:
          if (char == 8'h3d) begin
            n_state = DATA;
            n_hex   = '0;
          end
        DATA:
          // spaces only before the first data digit
          if (is_sp && hex_cnt == 4'd0) n_state = DATA;
          else if (is_hex) begin
            n_hex   = hex_cnt + 4'd1;
            n_state = (hex_cnt == 4'd7) ? HASH : DATA;
          end
        HASH:
          if (char == 8'h23) n_state = is_mem ? DONE_MEM : DONE_REG;
        default: n_state = IDLE;
      endcase
    end
  end

  logic [14:0] half, div;
  logic        time_err, pc_err, addr_err, grf_err;

  assign half     = freq[15:1];
  assign div      = (half == 15'd0) ? 15'd1 : half;
  assign time_err = (half == 15'd0) || ((({1'b0, time_acc}) % div) != 15'd0);
  assign pc_err   = (pc_acc < 32'h0000_3000) || (pc_acc > 32'h0000_4fff) || (pc_acc[1:0] != 2'b00);
  assign addr_err = (addr_acc > 32'h0000_2fff) || (addr_acc[1:0] != 2'b00);
  assign grf_err  = (grf_acc > 14'd31);

  always_comb begin
    format_type = 2'b00;
    error_code  = 4'b0000;
    case (state)
      DONE_REG: begin
        format_type = 2'b01;
        error_code  = {grf_err, 1'b0, pc_err, time_err};
      end
      DONE_MEM: begin
        format_type = 2'b10;
        error_code  = {1'b0, addr_err, pc_err, time_err};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_output_checker.sv
// Directed bench for cpu_output_checker: record recognition, error flags, aborts and restarts.
module tb_cpu_output_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ch;
  logic [15:0] freq;
  logic [1:0]  format_type;
  logic [3:0]  error_code;
  int          checks = 0;
  int          failures = 0;

  cpu_output_checker dut (
    .clk(clk), .reset(reset), .char(ch), .freq(freq),
    .format_type(format_type), .error_code(error_code)
  );

  always #5 clk = ~clk;

  task automatic send_char(input logic [7:0] c);
    ch = c;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // OR of format_type seen after every character of s
  task automatic feed_watch(input string s, output logic [1:0] seen);
    seen = 2'b00;
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      seen = seen | format_type;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ch    = 8'h20;
    freq  = 16'd2;
    #12;
    checks++;
    if (format_type !== 2'b00) begin failures++; $display("FAIL reset_fmt got=%b exp=00", format_type); end
    checks++;
    if (error_code !== 4'b0000) begin failures++; $display("FAIL reset_err got=%b exp=0000", error_code); end
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reg_record;
    logic [1:0] seen;
    freq = 16'd2;
    feed("^1024@000030fc:    $2   <=    89abcdef#");
    checks++;
    if (format_type !== 2'b01) begin failures++; $display("FAIL reg_fmt got=%b exp=01", format_type); end
    checks++;
    if (error_code !== 4'b0000) begin failures++; $display("FAIL reg_err got=%b exp=0000", error_code); end
    feed_watch("64#^", seen);
    checks++;
    if (seen !== 2'b00) begin failures++; $display("FAIL reg_one_cycle got=%b exp=00", seen); end
  endtask

  task automatic test_mem_record;
    freq = 16'd4;
    feed("^10@00003000:*00000ffc<=12345678#");
    checks++;
    if (format_type !== 2'b10) begin failures++; $display("FAIL mem_fmt got=%b exp=10", format_type); end
    checks++;
    if (error_code !== 4'b0000) begin failures++; $display("FAIL mem_err got=%b exp=0000", error_code); end
    // freq is used combinationally while the flag is up
    #2 freq = 16'd6;
    #1;
    checks++;
    if (error_code !== 4'b0001) begin failures++; $display("FAIL freq_change got=%b exp=0001", error_code); end
    freq = 16'd4;
  endtask

  task automatic test_errors;
    freq = 16'd4;
    feed("^7@00002ffe:$40<=00000000#");
    checks++;
    if (format_type !== 2'b01) begin failures++; $display("FAIL err_reg_fmt got=%b exp=01", format_type); end
    checks++;
    if (error_code !== 4'b1011) begin failures++; $display("FAIL err_reg got=%b exp=1011", error_code); end
    feed("^8@00004ffc:*00003001 <= 0000000a#");
    checks++;
    if (format_type !== 2'b10) begin failures++; $display("FAIL err_mem_fmt got=%b exp=10", format_type); end
    checks++;
    if (error_code !== 4'b0100) begin failures++; $display("FAIL err_mem got=%b exp=0100", error_code); end
    feed("^2@00003000:$31<=00000000#");
    checks++;
    if (error_code !== 4'b0000) begin failures++; $display("FAIL grf31 got=%b exp=0000", error_code); end
    feed("^2@00003000:$32<=00000000#");
    checks++;
    if (error_code !== 4'b1000) begin failures++; $display("FAIL grf32 got=%b exp=1000", error_code); end
    freq = 16'd1;
    feed("^10@00003000:*00000ffc<=12345678#");
    checks++;
    if (error_code !== 4'b0001) begin failures++; $display("FAIL half_zero got=%b exp=0001", error_code); end
    freq = 16'd4;
  endtask

  task automatic test_malformed;
    logic [1:0] seen;
    string bad [4];
    bad[0] = "^12345@00003000:$0<=00000000#";
    bad[1] = "^1@000030000:$0<=00000000#";
    bad[2] = "^1@00003000:$0<=0000000A#";
    bad[3] = "^1 @00003000:$0<=00000000#";
    for (int k = 0; k < 4; k++) begin
      feed_watch(bad[k], seen);
      checks++;
      if (seen !== 2'b00) begin failures++; $display("FAIL malformed_%0d got=%b exp=00", k, seen); end
    end
  endtask

  task automatic test_restart;
    freq = 16'd2;
    feed("^^1@00003000:$0<=00000000#");
    checks++;
    if (format_type !== 2'b01) begin failures++; $display("FAIL restart_fmt got=%b exp=01", format_type); end
    checks++;
    if (error_code !== 4'b0000) begin failures++; $display("FAIL restart_err got=%b exp=0000", error_code); end
  endtask

  task automatic test_back_to_back;
    freq = 16'd4;
    feed("^10@00003000:*00000ffc<=12345678#");
    checks++;
    if (format_type !== 2'b10) begin failures++; $display("FAIL b2b_first got=%b exp=10", format_type); end
    feed("^7@00002ffe:$40<=00000000#");
    checks++;
    if ({format_type, error_code} !== 6'b01_1011) begin
      failures++; $display("FAIL b2b_second got=%b/%b exp=01/1011", format_type, error_code);
    end
  endtask

  task automatic test_reset_midframe;
    logic [1:0] seen;
    freq = 16'd2;
    feed("^1@0000");
    reset = 1'b0;
    #1;
    checks++;
    if (format_type !== 2'b00) begin failures++; $display("FAIL rst_mid_fmt got=%b exp=00", format_type); end
    @(posedge clk); #1;
    reset = 1'b1;
    feed_watch("3000:$0<=00000000#", seen);
    checks++;
    if (seen !== 2'b00) begin failures++; $display("FAIL rst_mid_abort got=%b exp=00", seen); end
    feed("^4@00003004:$5<=00000000#");
    checks++;
    if (format_type !== 2'b01) begin failures++; $display("FAIL rst_done_pre got=%b exp=01", format_type); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({format_type, error_code} !== 6'b00_0000) begin
      failures++; $display("FAIL rst_done got=%b/%b exp=00/0000", format_type, error_code);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    feed("^4@00003004:$5<=00000000#");
    checks++;
    if ({format_type, error_code} !== 6'b01_0000) begin
      failures++; $display("FAIL rst_after got=%b/%b exp=01/0000", format_type, error_code);
    end
  endtask

  initial begin
    test_reset;
    test_reg_record;
    test_mem_record;
    test_errors;
    test_malformed;
    test_restart;
    test_back_to_back;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
